// File: rtl/fader_cos_accum_pkg.sv
// fader_cos_accum_pkg: shared sizes, types and the quarter-wave cosine table.
package fader_cos_accum_pkg;
    localparam int M        = 8;
    localparam int N        = 32;
    localparam int LOG2M    = $clog2(M);
    localparam int CHAN_W   = $clog2(N);
    localparam int PHASE_W  = 14;
    localparam int AMP_W    = 16;
    localparam int QW_DEPTH = 4096;
    localparam int QW_AW    = $clog2(QW_DEPTH);
    localparam int ACC_W    = AMP_W + LOG2M;
    localparam int ROM_W    = AMP_W - 1;
    localparam int IDX_W    = $clog2(QW_DEPTH * ROM_W);
    typedef logic [PHASE_W-1:0]             phase_t;
    typedef logic signed [AMP_W-1:0]        amp_t;
    typedef logic signed [ACC_W-1:0]        acc_t;
    typedef logic [CHAN_W-1:0]              chan_t;
    typedef logic [LOG2M-1:0]               refl_t;
    typedef logic [QW_DEPTH*ROM_W-1:0]      qw_rom_t;
    // Quarter-wave entries are all non-negative, so only the magnitude bits are stored.
    function automatic qw_rom_t qw_table();
        qw_rom_t t;
        logic [IDX_W-1:0] b;
        t = '0;
        for (int h = 0; h < QW_DEPTH / 64; h++) begin
            for (int l = 0; l < 64; l++) begin
                b = IDX_W'((h * 64 + l) * ROM_W);
                t[b +: ROM_W] = ROM_W'($rtoi(32767.0 * $cos(2.0 * 3.14159265358979323846 *
                    (real'(h * 64 + l) + 0.5) / real'(QW_DEPTH * 4)) + 0.5));
            end
        end
        return t;
    endfunction
    localparam qw_rom_t QW_ROM = qw_table();
endpackage

// File: rtl/fader_cos_accum_if.sv
// fader_cos_accum_if: phase-argument beats in, normalised complex fading samples out.
interface fader_cos_accum_if;
    import fader_cos_accum_pkg::*;
    logic   arg_valid;
    chan_t  arg_chan;
    refl_t  arg_m;
    phase_t arg_real;
    phase_t arg_imag;
    logic   dv_out;
    chan_t  chan_out;
    amp_t   Zc_real;
    amp_t   Zc_imag;
    logic   err_seq;
    modport master (
        output arg_valid, arg_chan, arg_m, arg_real, arg_imag,
        input  dv_out, chan_out, Zc_real, Zc_imag, err_seq
    );
    modport slave (
        input  arg_valid, arg_chan, arg_m, arg_real, arg_imag,
        output dv_out, chan_out, Zc_real, Zc_imag, err_seq
    );
endinterface

// File: rtl/fader_cos_accum_rom.sv
// fader_cos_accum_rom: 3-cycle cosine lookup, folding a full-turn phase onto the quarter-wave table.
module fader_cos_accum_rom
    import fader_cos_accum_pkg::*;
(
    input  logic   clk,
    input  phase_t phase_i,
    output amp_t   cos_o
);
    logic [QW_AW-1:0] addr_q;
    logic             neg1_q, neg2_q;
    logic [ROM_W-1:0] mag_q;
    amp_t             cos_q;
    // Odd quadrants read mirrored (4095-i == ~i); quadrants 1 and 2 are negative.
    always_ff @(posedge clk) begin
        addr_q <= phase_i[PHASE_W-2] ? ~phase_i[QW_AW-1:0] : phase_i[QW_AW-1:0];
        neg1_q <= ^phase_i[PHASE_W-1 -: 2];
        mag_q  <= QW_ROM[IDX_W'(addr_q) * IDX_W'(ROM_W) +: ROM_W];
        neg2_q <= neg1_q;
        cos_q  <= neg2_q ? -amp_t'(mag_q) : amp_t'(mag_q);
    end
    assign cos_o = cos_q;
endmodule

// File: rtl/fader_cos_accum.sv
// fader_cos_accum: sums M cosine terms per channel, normalises by 1/M and flags reflector
// sequence errors; results appear four cycles after the beat carrying m==0.
module fader_cos_accum
    import fader_cos_accum_pkg::*;
(
    input logic              clk,
    input logic              reset,
    fader_cos_accum_if.slave bus
);
    localparam int D = 3;
    amp_t          term_re, term_im;
    logic [D-1:0]  v_q;
    refl_t [D-1:0] m_q;
    chan_t [D-1:0] ch_q;
    acc_t          acc_re_q, acc_re_d, acc_im_q, acc_im_d, sum_re, sum_im;
    logic          open_q, open_d, dv_q, dv_d, err_q, err_d;
    refl_t         exp_q, exp_d;
    chan_t         gch_q, gch_d, chan_q, chan_d;
    amp_t          zr_q, zr_d, zi_q, zi_d;
    logic          v, first, bad;
    refl_t         m;
    chan_t         ch;

    fader_cos_accum_rom u_rom_re (.clk(clk), .phase_i(bus.arg_real), .cos_o(term_re));
    fader_cos_accum_rom u_rom_im (.clk(clk), .phase_i(bus.arg_imag), .cos_o(term_im));

    function automatic amp_t norm(acc_t s);
        acc_t r;
        r = (s + acc_t'(M / 2)) >>> LOG2M;
        return r[AMP_W-1:0];
    endfunction

    always_comb begin
        v        = v_q[D-1];
        m        = m_q[D-1];
        ch       = ch_q[D-1];
        sum_re   = acc_re_q + acc_t'(term_re);
        sum_im   = acc_im_q + acc_t'(term_im);
        first    = m == refl_t'(M - 1);
        bad      = !open_q || m != exp_q || ch != gch_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        open_d   = open_q;
        exp_d    = exp_q;
        gch_d    = gch_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        chan_d   = chan_q;
        zr_d     = zr_q;
        zi_d     = zi_q;
        if (v && first) begin
            acc_re_d = acc_t'(term_re);
            acc_im_d = acc_t'(term_im);
            open_d   = 1'b1;
            gch_d    = ch;
            exp_d    = refl_t'(M - 2);
            err_d    = open_q;
        end else if (v && bad) begin
            open_d = 1'b0;
            err_d  = 1'b1;
        end else if (v) begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            exp_d    = m - 1'b1;
            if (m == '0) begin
                dv_d   = 1'b1;
                chan_d = ch;
                zr_d   = norm(sum_re);
                zi_d   = norm(sum_im);
                open_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        m_q  <= {m_q[D-2:0], bus.arg_m};
        ch_q <= {ch_q[D-2:0], bus.arg_chan};
        if (reset) begin
            v_q      <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            open_q   <= 1'b0;
            exp_q    <= '0;
            gch_q    <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            chan_q   <= '0;
            zr_q     <= '0;
            zi_q     <= '0;
        end else begin
            v_q      <= {v_q[D-2:0], bus.arg_valid};
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            open_q   <= open_d;
            exp_q    <= exp_d;
            gch_q    <= gch_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            chan_q   <= chan_d;
            zr_q     <= zr_d;
            zi_q     <= zi_d;
        end
    end

    assign bus.dv_out   = dv_q;
    assign bus.err_seq  = err_q;
    assign bus.chan_out = chan_q;
    assign bus.Zc_real  = zr_q;
    assign bus.Zc_imag  = zi_q;
endmodule

// File: tb/tb_fader_cos_accum.sv
// tb_fader_cos_accum: directed and random groups checked every cycle against a cosine-sum model.
module tb_fader_cos_accum;
    import fader_cos_accum_pkg::*;
    localparam int  MAXC = 1024;
    localparam real PI   = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    fader_cos_accum_if bus ();
    fader_cos_accum dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0, n_dv = 0, n_err = 0;
    bit chk_en = 1'b0;
    bit ex_dv [MAXC];
    bit ex_err [MAXC];
    int ex_ch [MAXC];
    int ex_re [MAXC];
    int ex_im [MAXC];
    bit md_open = 1'b0;
    int md_ch = 0, md_next = 0, md_re = 0, md_im = 0, m0_cycle = 0;
    int last_ch = 0, last_re = 0, last_im = 0, dv_cycle = 0, ci = 0, d0 = 0, e0 = 0;
    int fr_re [N][M];
    int fr_im [N][M];

    function automatic int cos_term(input int p);
        real x = 32767.0 * $cos(2.0 * PI * (real'(p) + 0.5) / 16384.0);
        return x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
    endfunction

    function automatic int norm_model(input int s);
        return $rtoi($floor((real'(s) + real'(M) / 2.0) / real'(M)));
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    // Beat sampled at the next edge; its effect is visible three edges later.
    task automatic model_beat(input int ch, input int m, input int pr, input int pim);
        int o;
        o = (cyc + 4) % MAXC;
        if (m == M - 1) begin
            ex_err[o] = md_open;
            md_open   = 1'b1;
            md_ch     = ch;
            md_next   = M - 2;
            md_re     = cos_term(pr);
            md_im     = cos_term(pim);
        end else if (!md_open || m != md_next || ch != md_ch) begin
            ex_err[o] = 1'b1;
            md_open   = 1'b0;
        end else begin
            md_re  += cos_term(pr);
            md_im  += cos_term(pim);
            md_next = m - 1;
            if (m == 0) begin
                ex_dv[o] = 1'b1;
                ex_ch[o] = ch;
                ex_re[o] = norm_model(md_re);
                ex_im[o] = norm_model(md_im);
                md_open  = 1'b0;
                m0_cycle = cyc + 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 4; k++) begin
            ex_dv[(cyc + k) % MAXC]  = 1'b0;
            ex_err[(cyc + k) % MAXC] = 1'b0;
        end
        md_open = 1'b0;
    endtask

    task automatic send(input int ch, input int m, input int pr, input int pim, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bus.arg_valid = 1'b0;
        end
        @(negedge clk);
        bus.arg_valid = 1'b1;
        bus.arg_chan  = chan_t'(ch);
        bus.arg_m     = refl_t'(m);
        bus.arg_real  = phase_t'(pr);
        bus.arg_imag  = phase_t'(pim);
        model_beat(ch, m, pr, pim);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.arg_valid = 1'b0;
        end
    endtask

    task automatic grp_const(input int ch, input int p_hi, input int p_lo);
        for (int m = M - 1; m >= 0; m--) send(ch, m, m >= M / 2 ? p_hi : p_lo, m >= M / 2 ? p_hi : p_lo, 0);
    endtask

    task automatic grp_rand(input int ch);
        for (int m = M - 1; m >= 0; m--) send(ch, m, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)), 0);
    endtask

    task automatic frame(input int maxgap);
        for (int c = N - 1; c >= 0; c--)
            for (int m = M - 1; m >= 0; m--)
                send(c, m, fr_re[c][m], fr_im[c][m], int'($urandom_range(0, maxgap)));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " dv_out"}, int'(bus.dv_out), 0);
        chk({nm, " err_seq"}, int'(bus.err_seq), 0);
        chk({nm, " chan_out"}, int'(bus.chan_out), 0);
        chk({nm, " Zc_real"}, int'(bus.Zc_real), 0);
        chk({nm, " Zc_imag"}, int'(bus.Zc_imag), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            ci = cyc % MAXC;
            chk("dv_out", int'(bus.dv_out), int'(ex_dv[ci]));
            chk("err_seq", int'(bus.err_seq), int'(ex_err[ci]));
            if (ex_dv[ci]) begin
                chk("chan_out", int'(bus.chan_out), ex_ch[ci]);
                chk("Zc_real", int'(bus.Zc_real), ex_re[ci]);
                chk("Zc_imag", int'(bus.Zc_imag), ex_im[ci]);
            end
            ex_dv[ci]  = 1'b0;
            ex_err[ci] = 1'b0;
        end
        if (bus.dv_out) begin
            n_dv++;
            last_ch  = int'(bus.chan_out);
            last_re  = int'(bus.Zc_real);
            last_im  = int'(bus.Zc_imag);
            dv_cycle = cyc + 1;
        end
        if (bus.err_seq) n_err++;
    end

    initial begin
        bus.arg_valid = 1'b0;
        bus.arg_chan  = '0;
        bus.arg_m     = '0;
        bus.arg_real  = '0;
        bus.arg_imag  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_zero("reset");
        chk_en = 1'b1;

        grp_const(5, 0, 0);
        idle(8);
        chk("latency", dv_cycle - m0_cycle, 4);
        chk("phase0 chan", last_ch, 5);
        chk("phase0 re", last_re, 32767);
        chk("phase0 im", last_im, 32767);
        grp_const(6, 8192, 8192);
        idle(8);
        chk("phase8192 re", last_re, -32767);
        chk("phase8192 im", last_im, -32767);
        grp_const(7, 4096, 4096);
        idle(8);
        chk("phase4096 re", last_re, -6);
        chk("phase4096 im", last_im, -6);
        grp_const(8, 0, 8192);
        idle(8);
        chk("cancel re", last_re, 0);
        chk("cancel im", last_im, 0);

        for (int c = 0; c < N; c++)
            for (int m = 0; m < M; m++) begin
                fr_re[c][m] = int'($urandom_range(0, 16383));
                fr_im[c][m] = int'($urandom_range(0, 16383));
            end
        d0 = n_dv;
        frame(0);
        idle(8);
        chk("frame dv count", n_dv - d0, N);
        chk("frame last chan", last_ch, 0);
        d0 = n_dv;
        frame(3);
        idle(8);
        chk("gapped frame dv count", n_dv - d0, N);

        d0 = n_dv;
        e0 = n_err;
        send(2, 7, 0, 0, 0);
        send(2, 6, 0, 0, 0);
        send(2, 5, 0, 0, 0);
        grp_const(3, 0, 8192);
        idle(8);
        chk("restart err count", n_err - e0, 1);
        chk("restart dv count", n_dv - d0, 1);
        chk("restart chan", last_ch, 3);

        d0 = n_dv;
        e0 = n_err;
        send(4, 7, 100, 200, 0);
        send(4, 6, 300, 400, 0);
        send(4, 4, 500, 600, 0);
        idle(8);
        chk("skip err count", n_err - e0, 1);
        chk("skip dv count", n_dv - d0, 0);

        d0 = n_dv;
        for (int m = M - 1; m >= 3; m--) send(1, m, 1000 * m, 2000 * m, 0);
        @(negedge clk);
        bus.arg_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk_zero("mid-group reset");
        idle(8);
        chk("mid-group reset dv count", n_dv - d0, 0);
        grp_rand(9);
        idle(8);
        chk("post-reset dv count", n_dv - d0, 1);
        chk("post-reset chan", last_ch, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
